serial_adder_ctrl: RTL and testbench

//   Sequencer that reuses one 1-bit full-adder slice over WIDTH cycles to add two

---
 rtl/serial_adder_ctrl.sv | 97 +++++++++
 tb/tb_serial_adder_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice reused over WIDTH cycles, LSB first.
// Optional feature macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-2:0] acc;
  logic             cy;
  logic             bit_s, bit_c;
  logic [WIDTH-1:0] acc_sh;
  logic             accept, last;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign {bit_c, bit_s} = full_add(opa[0], opb[0], cy);
  // New bit enters from the MSB side; after WIDTH steps acc_sh holds the full result.
  assign acc_sh = {bit_s, acc};
  assign last   = (cnt == CNT_LAST);
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cy    <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      cnt <= '0;
      opa <= a;
      opb <= b;
      acc <= '0;
      cy  <= c_in;
    end else if (state == RUN) begin
      opa <= opa >> 1;
      opb <= opb >> 1;
      acc <= acc_sh[WIDTH-1:1];
      cy  <= bit_c;
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        sum   <= acc_sh;
        c_out <= bit_c;
`ifdef SERIAL_ADD_OVF_EN
        // cy is the carry into the MSB on this final step
        ovf   <= cy ^ bit_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed table-driven bench for serial_adder_ctrl (WIDTH=8) plus multi-cycle corner sequences.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk, rst, start, c_in;
  logic [W-1:0] a, b, sum;
  logic         busy, done, c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf),
`endif
    .c_out(c_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    start = 1'b1; a = va; b = vb; c_in = vc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask

  // Waits (bounded) for done; lat counts cycles after the accepting edge.
  task automatic wait_done(input logic [W-1:0] prev_sum, output int lat,
                           output int busy_n, output bit hold_ok);
    lat = -1; busy_n = 0; hold_ok = 1'b1;
    for (int j = 0; j < 24; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      if (busy) busy_n++;
      if (sum !== prev_sum) hold_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  int           lat, busy_n, n_done;
  bit           hold_ok;
  logic [W-1:0] prev_sum;

  initial begin
    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
    vecs[8] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", c_out, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("reset_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    prev_sum = '0;

    for (int i = 0; i < 9; i++) begin
      drive_start(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(prev_sum, lat, busy_n, hold_ok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 8);
      chk($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 8);
      chk($sformatf("v%0d_sum_held_during_run", i), 64'(hold_ok), 1);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
      chk($sformatf("v%0d_cout", i), c_out, vecs[i].exp_cout);
`ifdef SERIAL_ADD_OVF_EN
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_single_pulse", i), done, 0);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_sum_hold_idle", i), sum, vecs[i].exp_sum);
      prev_sum = vecs[i].exp_sum;
    end

    // start while busy must be ignored
    drive_start(8'h5A, 8'h33, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h11; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(prev_sum, lat, busy_n, hold_ok);
    chk("ign_latency", 64'(lat + 3), 8);
    chk("ign_sum", sum, 8'h8D);
    chk("ign_cout", c_out, 0);
    n_done = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("ign_no_extra_done", 64'(n_done), 0);
    prev_sum = 8'h8D;

    // back-to-back: start held during DONE cycle
    drive_start(8'h5A, 8'h33, 1'b0);
    wait_done(prev_sum, lat, busy_n, hold_ok);
    chk("b2b_first_latency", 64'(lat), 8);
    drive_start(8'h01, 8'h02, 1'b0);
    wait_done(8'h8D, lat, busy_n, hold_ok);
    chk("b2b_done_gap", 64'(lat + 1), 9);
    chk("b2b_sum", sum, 8'h03);
    chk("b2b_cout", c_out, 0);
    repeat (2) @(negedge clk);

    // reset in the 4th RUN cycle discards the add
    drive_start(8'h5A, 8'h33, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", c_out, 0);
    n_done = 0;
    for (int j = 0; j < 10; j++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(n_done), 0);
    drive_start(8'h10, 8'h20, 1'b0);
    wait_done(8'h00, lat, busy_n, hold_ok);
    chk("postrst_latency", 64'(lat), 8);
    chk("postrst_sum", sum, 8'h30);
    chk("postrst_cout", c_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
